// File: rtl/alu_issue_ctrl.sv
// Issue controller for an 8-bit combinational ALU: accepts one register-to-register
// instruction at a time, sequences the ALU, writes back and returns each result.
module alu_issue_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int IW    = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic             inst_ldi_i,
  input  logic [2:0]       inst_op_i,
  input  logic [IW-1:0]    inst_rd_i,
  input  logic [IW-1:0]    inst_rs1_i,
  input  logic [IW-1:0]    inst_rs2_i,
  input  logic [WIDTH-1:0] inst_imm_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [IW-1:0]    res_rd_o,
  output logic [15:0]      retired_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             idle_r;
  logic             res_valid_r;
  logic [WIDTH-1:0] rf_r [NREG];
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_op_r;
  logic [IW-1:0]    rd_r;
  logic [WIDTH-1:0] res_data_r;
  logic [IW-1:0]    res_rd_r;
  logic [15:0]      retired_r;
  logic             accept_s;

  // Ready is masked by reset so nothing can be accepted while reset is held.
  assign inst_ready_o = idle_r & rst_ni;
  assign accept_s     = inst_valid_i & inst_ready_o;
  assign alu_a_o      = alu_a_r;
  assign alu_b_o      = alu_b_r;
  assign alu_op_o     = alu_op_r;
  assign res_valid_o  = res_valid_r;
  assign res_data_o   = res_data_r;
  assign res_rd_o     = res_rd_r;
  assign retired_o    = retired_r;

  // Next-state decode for the IDLE -> EXEC/RESP -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (inst_ldi_i) begin
            state_s = RESP;
          end else begin
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (res_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, decoded status flags, register file and result datapath.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      idle_r      <= 1'b1;
      res_valid_r <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= '0;
      end
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_op_r   <= 3'd0;
      rd_r       <= '0;
      res_data_r <= '0;
      res_rd_r   <= '0;
      retired_r  <= 16'd0;
    end else begin
      state_r     <= state_s;
      idle_r      <= (state_s == IDLE);
      res_valid_r <= (state_s == RESP);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (inst_ldi_i) begin
              rf_r[inst_rd_i] <= inst_imm_i;
              res_data_r      <= inst_imm_i;
              res_rd_r        <= inst_rd_i;
            end else begin
              // Operands are read at accept, so back-to-back dependencies see fresh values.
              alu_a_r  <= rf_r[inst_rs1_i];
              alu_b_r  <= rf_r[inst_rs2_i];
              alu_op_r <= inst_op_i;
              rd_r     <= inst_rd_i;
            end
          end
        end
        EXEC: begin
          rf_r[rd_r] <= alu_res_i;
          res_data_r <= alu_res_i;
          res_rd_r   <= rd_r;
        end
        RESP: begin
          if (res_ready_i) begin
            retired_r <= retired_r + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a table of instructions with hand-computed
// results, plus sequences for backpressure, issue timing, mid-op reset and counter wrap.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       inst_valid;
  logic       inst_ready;
  logic       inst_ldi;
  logic [2:0] inst_op;
  logic [1:0] inst_rd, inst_rs1, inst_rs2;
  logic [7:0] inst_imm;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       ldi;
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [14];
  vec_t tv   [4];

  alu_issue_ctrl #(.WIDTH(8), .NREG(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
    .inst_ldi_i(inst_ldi), .inst_op_i(inst_op),
    .inst_rd_i(inst_rd), .inst_rs1_i(inst_rs1), .inst_rs2_i(inst_rs2),
    .inst_imm_i(inst_imm),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_rd_o(res_rd), .retired_o(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference combinational ALU seen by the controller.
  always_comb begin
    case (alu_op)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_a - alu_b;
      3'd2: alu_res = alu_a << alu_b[2:0];
      3'd3: alu_res = alu_a >> alu_b[2:0];
      3'd4: alu_res = alu_a & alu_b;
      3'd5: alu_res = alu_a | alu_b;
      3'd6: alu_res = alu_a ^ alu_b;
      default: alu_res = {7'd0, (alu_a == alu_b)};
    endcase
  end

  function automatic vec_t mk(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] rs1, input logic [1:0] rs2,
                              input logic [7:0] imm, input logic [7:0] exp);
    vec_t v;
    v.ldi = ldi; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    inst_ldi = v.ldi; inst_op = v.op; inst_rd = v.rd;
    inst_rs1 = v.rs1; inst_rs2 = v.rs2; inst_imm = v.imm;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!inst_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept_timeout"}, (n < 50), 1);
  endtask

  // Issue one instruction with res_ready high and check latency, data and rd.
  task automatic issue(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    drive(v);
    inst_valid = 1'b1;
    res_ready  = 1'b1;
    wait_ready(name);
    @(negedge clk);
    inst_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, v.ldi ? 1 : 2);
    check({name, "_data"}, res_data, v.exp);
    check({name, "_rd"}, res_rd, v.rd);
    @(negedge clk);
    check({name, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    int acc_prev;
    int acc_cyc;
    vec_t v;

    vecs[0]  = mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05);
    vecs[1]  = mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03);
    vecs[2]  = mk(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h08);
    vecs[3]  = mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF);
    vecs[4]  = mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01);
    vecs[5]  = mk(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00);
    vecs[6]  = mk(1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 8'h02);
    vecs[7]  = mk(1'b0, 3'd7, 2'd3, 2'd0, 2'd0, 8'h00, 8'h01);
    vecs[8]  = mk(1'b0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 8'hFE);
    vecs[9]  = mk(1'b0, 3'd3, 2'd2, 2'd2, 2'd1, 8'h00, 8'h7F);
    vecs[10] = mk(1'b0, 3'd4, 2'd3, 2'd2, 2'd0, 8'h00, 8'h7F);
    vecs[11] = mk(1'b0, 3'd6, 2'd3, 2'd2, 2'd1, 8'h00, 8'h7E);
    vecs[12] = mk(1'b0, 3'd5, 2'd0, 2'd3, 2'd1, 8'h00, 8'h7F);
    vecs[13] = mk(1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 8'h02);
    tv[0] = mk(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 8'h00, 8'h7D);
    tv[1] = mk(1'b0, 3'd6, 2'd3, 2'd0, 2'd1, 8'h00, 8'h7D);
    tv[2] = mk(1'b0, 3'd4, 2'd3, 2'd0, 2'd1, 8'h00, 8'h02);
    tv[3] = mk(1'b0, 3'd5, 2'd3, 2'd0, 2'd1, 8'h00, 8'h7F);

    rst_ni = 1'b0; inst_valid = 1'b0; res_ready = 1'b0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_inst_ready", inst_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_rd", res_rd, 0);
    check("rst_retired", retired, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_ready", inst_ready, 1);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i], $sformatf("vec%0d", i));
      if (i == 2) check("retired_after_3", retired, 3);
    end
    check("retired_after_table", retired, 14);

    // Backpressure: ADD r2=r0+r1 (0x7F+0x02) held for 5 cycles, LDI r3 queued behind it.
    @(negedge clk);
    drive(mk(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h81));
    inst_valid = 1'b1;
    res_ready  = 1'b0;
    wait_ready("bp_add");
    @(negedge clk);
    drive(mk(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'hAA, 8'hAA));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 8'h81);
      check("bp_rd", res_rd, 2);
      check("bp_inst_ready", inst_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_valid", res_valid, 0);
    check("bp_idle_ready", inst_ready, 1);
    check("bp_retired_a", retired, 15);
    @(negedge clk);
    inst_valid = 1'b0;
    check("bp_second_valid", res_valid, 1);
    check("bp_second_data", res_data, 8'hAA);
    check("bp_second_rd", res_rd, 3);
    @(negedge clk);
    check("bp_retired_b", retired, 16);

    // Back-to-back ALU ops with valid held high.
    @(negedge clk);
    drive(tv[0]);
    inst_valid = 1'b1;
    acc_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready("tm");
      acc_cyc = cyc;
      if (k > 0) check("tm_spacing", acc_cyc - acc_prev, 3);
      acc_prev = acc_cyc;
      check("tm_op_before_exec", (alu_op == tv[k].op), 0);
      @(negedge clk);
      if (k < 3) drive(tv[k + 1]);
      else inst_valid = 1'b0;
      check("tm_op_exec", alu_op, tv[k].op);
      check("tm_ab_exec", {alu_a, alu_b}, 16'h7F02);
      check("tm_valid_exec", res_valid, 0);
      @(negedge clk);
      check("tm_valid_resp", res_valid, 1);
      check("tm_data", res_data, tv[k].exp);
      check("tm_ready_resp", inst_ready, 0);
      @(negedge clk);
    end
    check("tm_retired", retired, 20);

    // Reset during EXEC of XOR r1=r0^r0 aborts the writeback.
    issue(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h5A, 8'h5A), "mr_ldi0");
    issue(mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h77, 8'h77), "mr_ldi1");
    @(negedge clk);
    drive(mk(1'b0, 3'd6, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00));
    inst_valid = 1'b1;
    wait_ready("mr_xor");
    @(negedge clk);
    inst_valid = 1'b0;
    check("mr_exec_op", alu_op, 6);
    rst_ni = 1'b0;
    @(negedge clk);
    check("mr_rst_valid", res_valid, 0);
    check("mr_rst_ready", inst_ready, 0);
    check("mr_rst_retired", retired, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("mr_post_ready", inst_ready, 1);
    check("mr_post_valid", res_valid, 0);
    issue(mk(1'b0, 3'd5, 2'd2, 2'd1, 2'd1, 8'h00, 8'h00), "mr_read_r1");
    issue(mk(1'b0, 3'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00), "mr_read_r0");
    check("mr_retired", retired, 2);

    // Retired counter wrap: preload near the top, then three LDI handshakes.
    @(negedge clk);
    force dut.retired_r = 16'hFFFD;
    @(negedge clk);
    release dut.retired_r;
    @(negedge clk);
    check("wrap_preload", retired, 16'hFFFD);
    issue(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11), "wrap0");
    check("wrap_fffe", retired, 16'hFFFE);
    issue(mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h22, 8'h22), "wrap1");
    check("wrap_ffff", retired, 16'hFFFF);
    issue(mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h33, 8'h33), "wrap2");
    check("wrap_zero", retired, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
